// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the in-order F->D->R->X core.
// Produces per-stage stall/flush controls for load-use hazards, multi-cycle execute ops,
// taken-branch redirects and debug halt/resume.
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to add stall/redirect perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned MULTI_CNT_WIDTH = 4,
  parameter int unsigned DRAIN_CYCLES    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] rd_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rd_rs2,
  input  logic                      rd_rs1_use,
  input  logic                      rd_rs2_use,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_rd_wr,
  input  logic                      ex_is_load,
  input  logic                      ex_multi_start,
  input  logic [MULTI_CNT_WIDTH-1:0] ex_multi_cycles,
  input  logic                      ex_redirect,
  input  logic [ADDR_WIDTH-3:0]     ex_redirect_addr,
  input  logic                      halt_req,
  input  logic                      resume_req,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_r,
  output logic                      stall_x,
  output logic                      flush_d,
  output logic                      flush_r,
  output logic                      flush_x,
  output logic                      fetch_redirect,
  output logic [ADDR_WIDTH-3:0]     fetch_redirect_addr,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_flushes,
`endif
  output logic                      halted
);

  localparam int unsigned DcntWidth = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StRun, StMulti, StDrain, StHalted} state_e;

  state_e                     state_q;
  logic [MULTI_CNT_WIDTH-1:0] cnt_q;
  logic [DcntWidth-1:0]       dcnt_q;
  logic                       halted_q;
  logic                       load_use;

  // Register 0 is hardwired zero, so it never creates a hazard.
  assign load_use = rd_valid & ex_valid & ex_rd_wr & ex_is_load & (ex_rd != '0) &
                    ((rd_rs1_use & (rd_rs1 == ex_rd)) | (rd_rs2_use & (rd_rs2 == ex_rd)));

  assign fetch_redirect_addr = ex_redirect_addr;
  assign halted              = halted_q;

  // Stage controls by priority: reset > multi-cycle op > redirect > load-use > drain/halt.
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_r        = 1'b0;
    stall_x        = 1'b0;
    flush_d        = 1'b0;
    flush_r        = 1'b0;
    flush_x        = 1'b0;
    fetch_redirect = 1'b0;
    if (!rst) begin
      flush_d = 1'b1;
      flush_r = 1'b1;
      flush_x = 1'b1;
    end else if (state_q == StMulti) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_r = 1'b1;
      stall_x = 1'b1;
    end else if (ex_redirect) begin
      fetch_redirect = 1'b1;
      flush_d        = 1'b1;
      flush_r        = 1'b1;
      flush_x        = 1'b1;
    end else if (load_use) begin
      // Hold F/D/R and inject a bubble into X.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_r = 1'b1;
      flush_x = 1'b1;
    end else if (state_q == StDrain || state_q == StHalted) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  // Control FSM: multi-cycle countdown, halt drain countdown and halted flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StRun;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_multi_start && ex_multi_cycles >= MULTI_CNT_WIDTH'(2)) begin
            state_q <= StMulti;
            cnt_q   <= ex_multi_cycles - MULTI_CNT_WIDTH'(1);
          end else if (halt_req && !ex_multi_start) begin
            state_q <= StDrain;
            dcnt_q  <= DcntWidth'(DRAIN_CYCLES);
          end
        end
        StMulti: begin
          if (cnt_q == MULTI_CNT_WIDTH'(1)) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - MULTI_CNT_WIDTH'(1);
          end
        end
        StDrain: begin
          // A load-use cycle does not advance the pipeline, so it does not count.
          if (!load_use) begin
            if (dcnt_q == DcntWidth'(1)) begin
              state_q  <= StHalted;
              dcnt_q   <= '0;
              halted_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q - DcntWidth'(1);
            end
          end
        end
        StHalted: begin
          if (resume_req) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running perf counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_r)        perf_stall_q <= perf_stall_q + 32'd1;
      if (fetch_redirect) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random stimulus,
// expected outputs produced by a cycle-level behavioural model of the controller.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    bit        rst;
    bit        rd_valid;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit        u1;
    bit        u2;
    bit        ex_valid;
    bit [4:0]  ex_rd;
    bit        wr;
    bit        ld;
    bit        ms;
    bit [3:0]  n;
    bit        redir;
    bit [29:0] addr;
    bit        halt;
    bit        resume;
  } stim_t;

  // {stall_f, stall_d, stall_r, stall_x, flush_d, flush_r, flush_x, fetch_redirect, halted}
  typedef struct packed {
    bit [8:0]  ctl;
    bit [29:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, rd_rs1_use, rd_rs2_use;
  logic [4:0]  rd_rs1, rd_rs2, ex_rd;
  logic        ex_valid, ex_rd_wr, ex_is_load, ex_multi_start, ex_redirect;
  logic [3:0]  ex_multi_cycles;
  logic [29:0] ex_redirect_addr, fetch_redirect_addr;
  logic        halt_req, resume_req;
  logic        stall_f, stall_d, stall_r, stall_x, flush_d, flush_r, flush_x;
  logic        fetch_redirect, halted;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
  int unsigned m_perf_stall = 0;
  int unsigned m_perf_flush = 0;
`endif

  pipe_hazard_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .rd_valid            (rd_valid),
    .rd_rs1              (rd_rs1),
    .rd_rs2              (rd_rs2),
    .rd_rs1_use          (rd_rs1_use),
    .rd_rs2_use          (rd_rs2_use),
    .ex_valid            (ex_valid),
    .ex_rd               (ex_rd),
    .ex_rd_wr            (ex_rd_wr),
    .ex_is_load          (ex_is_load),
    .ex_multi_start      (ex_multi_start),
    .ex_multi_cycles     (ex_multi_cycles),
    .ex_redirect         (ex_redirect),
    .ex_redirect_addr    (ex_redirect_addr),
    .halt_req            (halt_req),
    .resume_req          (resume_req),
    .stall_f             (stall_f),
    .stall_d             (stall_d),
    .stall_r             (stall_r),
    .stall_x             (stall_x),
    .flush_d             (flush_d),
    .flush_r             (flush_r),
    .flush_x             (flush_x),
    .fetch_redirect      (fetch_redirect),
    .fetch_redirect_addr (fetch_redirect_addr),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_flushes        (perf_flushes),
`endif
    .halted              (halted)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  // Reference model: mode plus number of stall/drain cycles still owed.
  localparam int MRun = 0, MMulti = 1, MDrain = 2, MHalted = 3;
  int m_mode = MRun;
  int m_left = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  // One cycle: drive inputs after the falling edge, queue the expected outputs, advance model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   hz;
    @(negedge clk);
    rst = s.rst; rd_valid = s.rd_valid; rd_rs1 = s.rs1; rd_rs2 = s.rs2;
    rd_rs1_use = s.u1; rd_rs2_use = s.u2; ex_valid = s.ex_valid; ex_rd = s.ex_rd;
    ex_rd_wr = s.wr; ex_is_load = s.ld; ex_multi_start = s.ms; ex_multi_cycles = s.n;
    ex_redirect = s.redir; ex_redirect_addr = s.addr; halt_req = s.halt; resume_req = s.resume;

    hz = s.rd_valid && s.ex_valid && s.wr && s.ld && s.ex_rd != 0 &&
         ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd));
    e = '0;
    e.addr = s.addr;
    e.ctl[0] = (m_mode == MHalted);
    if (!s.rst)                  e.ctl[8:1] = 8'b0000_1110;
    else if (m_mode == MMulti)   e.ctl[8:1] = 8'b1111_0000;
    else if (s.redir)            e.ctl[8:1] = 8'b0000_1111;
    else if (hz)                 e.ctl[8:1] = 8'b1110_0010;
    else if (m_mode == MDrain || m_mode == MHalted) e.ctl[8:1] = 8'b1000_1000;
    exp_q.push_back(e);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (!s.rst) begin
      m_perf_stall = 0; m_perf_flush = 0;
    end else begin
      if (e.ctl[6]) m_perf_stall++;
      if (e.ctl[1]) m_perf_flush++;
    end
`endif

    if (!s.rst) begin
      m_mode = MRun; m_left = 0;
    end else begin
      case (m_mode)
        MRun: begin
          if (s.ms && s.n >= 2) begin m_mode = MMulti; m_left = int'(s.n) - 1; end
          else if (s.halt && !s.ms) begin m_mode = MDrain; m_left = 3; end
        end
        MMulti: begin m_left--; if (m_left == 0) m_mode = MRun; end
        MDrain: if (!hz) begin m_left--; if (m_left == 0) m_mode = MHalted; end
        default: if (s.resume) m_mode = MRun;
      endcase
    end
  endtask

  // Monitor: outputs are valid every cycle; sample mid-low-phase and compare with queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({stall_f, stall_d, stall_r, stall_x, flush_d, flush_r, flush_x, fetch_redirect,
             halted} !== e.ctl) begin
          fails++;
          $display("FAIL ctl @%0t: got %b want %b (sf sd sr sx fd fr fx redir halted)",
                   $time, {stall_f, stall_d, stall_r, stall_x, flush_d, flush_r, flush_x,
                   fetch_redirect, halted}, e.ctl);
        end
        tests++;
        if (fetch_redirect_addr !== e.addr) begin
          fails++;
          $display("FAIL redirect_addr @%0t: got %h want %h", $time, fetch_redirect_addr,
                   e.addr);
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    step(s); step(s);

    // Load-use on rs1, then clear.
    s = idle(); s.rd_valid = 1; s.rs1 = 5; s.u1 = 1; s.ex_valid = 1; s.ex_rd = 5;
    s.wr = 1; s.ld = 1;
    step(s); step(idle());
    // Load to x0 never hazards.
    s.rs1 = 0; s.ex_rd = 0;
    step(s);
    // Multi-cycle N=4, then N=1.
    s = idle(); s.ms = 1; s.n = 4;
    step(s); repeat (4) step(idle());
    s.n = 1;
    step(s); step(idle());
    // Redirect overriding load-use.
    s = idle(); s.rd_valid = 1; s.rs2 = 7; s.u2 = 1; s.ex_valid = 1; s.ex_rd = 7;
    s.wr = 1; s.ld = 1; s.redir = 1; s.addr = 30'h100;
    step(s);
    // Halt, drain, resume.
    s = idle(); s.halt = 1;
    step(s); repeat (4) step(idle());
    s = idle(); s.resume = 1;
    step(s); step(idle());
    // Reset in the middle of a multi-cycle op.
    s = idle(); s.ms = 1; s.n = 6;
    step(s); step(idle());
    s = idle(); s.rst = 0;
    step(s); repeat (3) step(idle());

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 99) != 0);
      s.rd_valid = $urandom_range(0, 3) != 0;
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.u1       = $urandom_range(0, 1);
      s.u2       = $urandom_range(0, 1);
      s.ex_valid = $urandom_range(0, 3) != 0;
      s.ex_rd    = 5'($urandom_range(0, 3));
      s.wr       = $urandom_range(0, 3) != 0;
      s.ld       = $urandom_range(0, 1);
      s.ms       = $urandom_range(0, 9) == 0;
      s.n        = 4'($urandom_range(0, 15));
      s.redir    = $urandom_range(0, 7) == 0;
      s.addr     = 30'($urandom);
      s.halt     = $urandom_range(0, 15) == 0;
      s.resume   = $urandom_range(0, 3) == 0;
      step(s);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    tests++;
    if (perf_stall_cycles !== m_perf_stall || perf_flushes !== m_perf_flush) begin
      fails++;
      $display("FAIL perf: got %0d/%0d want %0d/%0d", perf_stall_cycles, perf_flushes,
               m_perf_stall, m_perf_flush);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
